// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the instruction-store loader.
package loader_pkg;

  localparam int         LD_ADDR_W    = 8;
  localparam int         LD_DATA_W    = 8;
  localparam logic [7:0] LD_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] LD_BASE_ADDR = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    CHECK
  } ld_state_e;

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit checksum of frame payload with clear, accumulate and compare.
module loader_csum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] byte_i,
  input  logic [DATA_W-1:0] ref_i,
  output logic              match_o
);

  logic [DATA_W-1:0] sum_q;

  // NOTE: reset is synchronous, so it lives inside the clocked block as an ordinary branch.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sum_q <= '0;
    end else if (acc_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign match_o = (sum_q == ref_i);

endmodule

// File: rtl/program_loader.sv
// Frame receiver that writes SYNC/LEN/DATA/CSUM payload into the instruction RAM.
module program_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = LD_ADDR_W,
  parameter int                DATA_W    = LD_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE = LD_SYNC_BYTE,
  parameter logic [ADDR_W-1:0] BASE_ADDR = LD_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_e         state_q;
  logic              rx_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_error_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   idx_d;
  logic [DATA_W-1:0] csum_q;
  logic              rx_accept;
  logic              csum_match;

  assign rx_accept = rx_valid & rx_ready_q;

  // NOTE: combinational helpers assign every output unconditionally so no latch is inferred.
  always_comb begin
    idx_d = idx_q + IDX_ONE;
  end

  loader_csum #(.DATA_W(DATA_W)) u_csum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   ((state_q == IDLE) && rx_accept && (rx_data == SYNC_BYTE)),
    .acc_i   ((state_q == DATA) && rx_accept),
    .byte_i  (rx_data),
    .ref_i   (csum_q),
    .match_o (csum_match)
  );

  // NOTE: all state and registered outputs use non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_accept && (rx_data == SYNC_BYTE)) begin
            state_q      <= LEN;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            idx_q        <= '0;
          end
        end
        LEN: begin
          if (rx_accept) begin
            len_q   <= (rx_data == '0) ? LEN_MAX : (ADDR_W + 1)'(rx_data);
            state_q <= DATA;
          end
        end
        DATA: begin
          if (rx_accept) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= BASE_ADDR + idx_q[ADDR_W-1:0];
            mem_wdata_q <= rx_data;
            idx_q       <= idx_d;
            if (idx_d == len_q) begin
              state_q <= CSUM;
            end
          end
        end
        CSUM: begin
          if (rx_accept) begin
            csum_q     <= rx_data;
            rx_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (csum_match) begin
            load_done_q <= 1'b1;
          end else begin
            load_error_q <= 1'b1;
          end
          cpu_hold_q <= 1'b0;
          rx_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: frames driven with $urandom gaps, checked against a frame-level model.
module tb_program_loader;

  localparam logic [7:0] BASE = 8'h00;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  a;
    logic [7:0]  d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   hold_win = 1'b0;
  bit   frame_win = 1'b0;
  int   hold_bad = 0;
  int   rdy_low = 0;
  wr_t  got_q[$];
  int   acc_q[$];
  logic [7:0] frm[$];

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (mem_we) got_q.push_back('{cyc: cyc, a: mem_waddr, d: mem_wdata});
    if (hold_win && !cpu_hold) hold_bad++;
    if (frame_win && !rx_ready) rdy_low++;
  end

  // Offer one byte from a negedge; returns at the negedge after the accepting posedge.
  task automatic drive_byte(input logic [7:0] b, output int ac, output bit ok);
    ok = 1'b0;
    ac = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (rx_ready) begin
        ac = cyc + 1;
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid toggled every cycle, 2 random idle gaps.
  task automatic run_frame(input string name, input int gap_mode);
    int s, n, sum, csum_idx, ac, bad_d, bad_t, lim;
    bit good, ok;
    logic [7:0] ea;
    s = -1;
    for (int i = 0; i < frm.size(); i++) begin
      if (frm[i] == 8'hA5) begin
        s = i;
        break;
      end
    end
    n = (frm[s+1] == 8'h00) ? 256 : int'(frm[s+1]);
    sum = 0;
    for (int k = 0; k < n; k++) sum += int'(frm[s+2+k]);
    csum_idx = s + 2 + n;
    good = ((sum % 256) == int'(frm[csum_idx]));
    got_q.delete();
    acc_q.delete();

    for (int j = 0; j <= csum_idx; j++) begin
      drive_byte(frm[j], ac, ok);
      if (!ok) begin
        total_cnt++;
        $display("FAIL %s timeout: byte %0d not accepted within 20 cycles", name, j);
        return;
      end
      if (j == s) begin
        total_cnt++;
        if ({cpu_hold, load_done, load_error} !== 3'b100)
          $display("FAIL %s sync_flags: hold/done/err=%b required 100", name,
                   {cpu_hold, load_done, load_error});
        else pass_cnt++;
        hold_bad  = 0;
        rdy_low   = 0;
        hold_win  = 1'b1;
        frame_win = 1'b1;
      end
      if (j >= s + 2 && j < csum_idx) acc_q.push_back(ac);
      if (j == csum_idx) begin
        total_cnt++;
        if ({rx_ready, cpu_hold} !== 2'b01)
          $display("FAIL %s check_cycle: ready/hold=%b required 01", name, {rx_ready, cpu_hold});
        else pass_cnt++;
        hold_win = 1'b0;
        @(negedge clk);
        frame_win = 1'b0;
        total_cnt++;
        if ({rx_ready, cpu_hold, load_done, load_error} !== {1'b1, 1'b0, good, !good})
          $display("FAIL %s result: ready/hold/done/err=%b required %b", name,
                   {rx_ready, cpu_hold, load_done, load_error}, {1'b1, 1'b0, good, !good});
        else pass_cnt++;
        total_cnt++;
        if (rdy_low != 1 || hold_bad != 0)
          $display("FAIL %s windows: ready_low=%0d hold_drops=%0d required 1 and 0", name,
                   rdy_low, hold_bad);
        else pass_cnt++;
      end else if (gap_mode == 1) begin
        @(negedge clk);
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    total_cnt++;
    if (got_q.size() != n)
      $display("FAIL %s write_count: got %0d required %0d", name, got_q.size(), n);
    else pass_cnt++;
    bad_d = 0;
    bad_t = 0;
    lim = (got_q.size() < n) ? got_q.size() : n;
    for (int k = 0; k < lim; k++) begin
      ea = BASE + 8'(k);
      if (got_q[k].a !== ea || got_q[k].d !== frm[s+2+k]) bad_d++;
      if (int'(got_q[k].cyc) != acc_q[k]) bad_t++;
    end
    total_cnt++;
    if (bad_d != 0) $display("FAIL %s write_data: %0d of %0d writes wrong, required 0", name, bad_d, lim);
    else pass_cnt++;
    total_cnt++;
    if (bad_t != 0) $display("FAIL %s write_latency: %0d writes not 1 cycle after accept, required 0",
                             name, bad_t);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_error} !== 21'h0)
      $display("FAIL reset_values: outputs=%h required 0",
               {rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_error});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame("basic", 0);
  endtask

  task automatic test_bad_csum();
    frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_frame("bad_csum", 0);
    frm = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03};
    run_frame("after_error", 0);
  endtask

  task automatic test_garbage();
    frm = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5, 8'hA5};
    run_frame("garbage", 0);
  endtask

  task automatic test_len256();
    int sum;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(8'h00);
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      frm.push_back(8'(i));
      sum += i;
    end
    frm.push_back(8'(sum));
    run_frame("len256", 0);
  endtask

  task automatic test_toggle_valid();
    frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame("toggle_valid", 1);
  endtask

  task automatic test_reset_mid_frame();
    int ac;
    bit ok;
    logic [7:0] pre[4];
    pre = '{8'hA5, 8'h03, 8'h11, 8'h22};
    got_q.delete();
    for (int j = 0; j < 4; j++) begin
      drive_byte(pre[j], ac, ok);
      if (!ok) begin
        total_cnt++;
        $display("FAIL rst_mid timeout: byte %0d not accepted", j);
        return;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_error} !== 21'h0)
      $display("FAIL rst_mid_values: outputs=%h required 0",
               {rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_error});
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() != 2 || got_q[0].a !== 8'h00 || got_q[0].d !== 8'h11 ||
        got_q[1].a !== 8'h01 || got_q[1].d !== 8'h22)
      $display("FAIL rst_mid_writes: got %0d writes, required 2 (00:11, 01:22)", got_q.size());
    else pass_cnt++;
    rst = 1'b0;
    frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame("after_rst", 0);
  endtask

  task automatic test_random();
    int n, sum;
    logic [7:0] b;
    for (int f = 0; f < 8; f++) begin
      frm.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        frm.push_back(b);
      end
      n = $urandom_range(1, 48);
      frm.push_back(8'hA5);
      frm.push_back(8'(n));
      sum = 0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        frm.push_back(b);
        sum += int'(b);
      end
      if ($urandom_range(0, 3) == 0) sum += 1;
      frm.push_back(8'(sum));
      run_frame($sformatf("random%0d", f), 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_csum();
    test_garbage();
    test_len256();
    test_toggle_valid();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
